// File: rtl/sandbox_pkg.sv
// Shared definitions for the sandbox command dispatcher: opcodes, status bit
// positions, FSM encodings and the command decode helper.
package sandbox_pkg;

    typedef enum logic [1:0] {
        OP_QUERY       = 2'b00,
        OP_START       = 2'b01,
        OP_ABORT       = 2'b10,
        OP_CLEAR_STATS = 2'b11
    } opcode_t;

    localparam int ST_ACCEPTED = 0;
    localparam int ST_BUSY     = 1;
    localparam int ST_DONE     = 2;
    localparam int ST_PASS     = 3;
    localparam int ST_INVALID  = 4;
    localparam int ST_TIMEOUT  = 5;

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_RESPOND, S_HOLD, S_ACK, S_WAIT_DROP
    } dispState_t;

    typedef enum logic [2:0] {
        I_IDLE, I_WAIT_HIGH_ON, I_WAIT_LOW_ON, I_WAIT_HIGH_OFF, I_WAIT_LOW_OFF
    } indState_t;

    typedef struct packed {
        logic [2:0] channel;
        opcode_t    opcode;
    } command_t;

    function automatic command_t decodeControl(input logic [4:0] ctrl);
        command_t cmd;
        cmd.channel = ctrl[4:2];
        cmd.opcode  = opcode_t'(ctrl[1:0]);
        return cmd;
    endfunction

endpackage

// File: rtl/sandbox_indicator.sv
// Receive-indicator blinker: one lamp period per accepted command, timed by two
// full slowClock periods; commands arriving mid-blink fold into it.
module sandbox_indicator
    import sandbox_pkg::*;
(
    input  logic masterClock,
    input  logic reset,
    input  logic slowClock,
    input  logic accept,
    output logic rxIndicator
);

    indState_t  state, stateNext;
    logic [1:0] slowSync;

    // slowClock is unrelated to masterClock, so resync before using its level
    always_ff @(posedge masterClock) begin
        if (!reset) begin
            state    <= I_IDLE;
            slowSync <= 2'b00;
        end else begin
            state    <= stateNext;
            slowSync <= {slowSync[0], slowClock};
        end
    end

    always_comb begin
        stateNext   = state;
        rxIndicator = 1'b0;
        case (state)
            I_IDLE:          if (accept)       stateNext = I_WAIT_HIGH_ON;
            I_WAIT_HIGH_ON:  if (slowSync[1])  stateNext = I_WAIT_LOW_ON;
            I_WAIT_LOW_ON:   if (!slowSync[1]) stateNext = I_WAIT_HIGH_OFF;
            I_WAIT_HIGH_OFF: begin
                rxIndicator = 1'b1;
                if (slowSync[1]) stateNext = I_WAIT_LOW_OFF;
            end
            I_WAIT_LOW_OFF: begin
                rxIndicator = 1'b1;
                if (!slowSync[1]) stateNext = I_IDLE;
            end
            default: stateNext = I_IDLE;
        endcase
    end

endmodule

// File: rtl/sandbox_dispatcher.sv
// Host command dispatcher: handshakes one command byte at a time, starts/aborts
// engine channels and reports per-channel status, run counts and timeouts.
module sandbox_dispatcher
    import sandbox_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DATA_W      = 32,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic                masterClock,
    input  logic                reset,
    input  logic                slowClock,
    input  logic                dataReceived,
    input  logic [7:0]          control,
    input  logic [DATA_W-1:0]   inputData,
    output logic                clearDR,
    output logic                transmitData,
    output logic [7:0]          status,
    output logic [DATA_W-1:0]   outputData,
    output logic                rxIndicator,
    output logic [NUM_CH-1:0]   engRun,
    input  logic [NUM_CH-1:0]   engBusy,
    input  logic [NUM_CH-1:0]   engDone,
    input  logic [NUM_CH-1:0]   engPass,
    input  logic [8*NUM_CH-1:0] engErrInstr
);

    localparam int WD_W = $clog2(TIMEOUT_CYC);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    dispState_t state, stateNext;
    command_t   cmdReg;
    logic       isDecode, chValid;
    logic [NUM_CH-1:0]            abortCh, clrCh, flagNext;
    logic [NUM_CH-1:0][CNT_W-1:0] cntNext;

    logic             selBusy, selDone, selPass, selFlag;
    logic [7:0]       selErr;
    logic [CNT_W-1:0] selCnt;
    logic [7:0]       statusNx;
    logic [DATA_W-1:0] dataNx;

    logic unusedInputs;
    assign unusedInputs = ^{inputData, control[7:5]};

    assign isDecode = (state == S_DECODE);
    assign chValid  = ({29'd0, cmdReg.channel} < 32'(NUM_CH));

    always_ff @(posedge masterClock) begin
        if (!reset) begin
            state      <= S_IDLE;
            cmdReg     <= '0;
            status     <= '0;
            outputData <= '0;
        end else begin
            state <= stateNext;
            if (state == S_IDLE && dataReceived)
                cmdReg <= decodeControl(control[4:0]);
            if (isDecode) begin
                status     <= statusNx;
                outputData <= dataNx;
            end
        end
    end

    always_comb begin
        stateNext    = state;
        transmitData = 1'b0;
        clearDR      = 1'b0;
        case (state)
            S_IDLE:    if (dataReceived) stateNext = S_DECODE;
            S_DECODE:  stateNext = S_RESPOND;
            S_RESPOND: begin transmitData = 1'b1; stateNext = S_HOLD; end
            S_HOLD:    begin transmitData = 1'b1; stateNext = S_ACK; end
            S_ACK: begin
                transmitData = 1'b1;
                clearDR      = 1'b1;
                stateNext    = S_WAIT_DROP;
            end
            S_WAIT_DROP: begin
                transmitData = 1'b1;
                clearDR      = 1'b1;
                if (!dataReceived) stateNext = S_IDLE;
            end
            default: stateNext = S_IDLE;
        endcase
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : gCh
        logic             chHit, expire, flagNx, toFlag;
        logic [CNT_W-1:0] runCnt, cntNx;
        logic [WD_W-1:0]  wdog;

        assign chHit      = isDecode && (cmdReg.channel == 3'(c));
        assign engRun[c]  = chHit && (cmdReg.opcode == OP_START) && !engBusy[c] && !engDone[c];
        assign abortCh[c] = chHit && (cmdReg.opcode == OP_ABORT);
        assign clrCh[c]   = chHit && (cmdReg.opcode == OP_CLEAR_STATS);
        assign expire     = engBusy[c] && (wdog == WD_LAST);

        // clear beats both abort and a watchdog expiry landing in the same cycle
        always_comb begin
            cntNx  = runCnt;
            flagNx = toFlag;
            if (clrCh[c]) begin
                cntNx  = '0;
                flagNx = 1'b0;
            end else begin
                if (engRun[c] && runCnt != '1) cntNx = runCnt + 1'b1;
                if (abortCh[c] || expire)      flagNx = 1'b1;
            end
        end

        always_ff @(posedge masterClock) begin
            if (!reset) begin
                runCnt <= '0;
                toFlag <= 1'b0;
                wdog   <= '0;
            end else begin
                runCnt <= cntNx;
                toFlag <= flagNx;
                if (!engBusy[c]) wdog <= '0;
                else if (!expire) wdog <= wdog + 1'b1;
            end
        end

        assign cntNext[c]  = cntNx;
        assign flagNext[c] = flagNx;
    end

    // Response reflects the post-command stats, so START/CLEAR answers are current
    always_comb begin
        selBusy = 1'b0;
        selDone = 1'b0;
        selPass = 1'b0;
        selFlag = 1'b0;
        selErr  = '0;
        selCnt  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (cmdReg.channel == 3'(c)) begin
                selBusy = engBusy[c];
                selDone = engDone[c];
                selPass = engPass[c];
                selFlag = flagNext[c];
                selErr  = engErrInstr[8*c +: 8];
                selCnt  = cntNext[c];
            end
        end
    end

    always_comb begin
        statusNx = '0;
        dataNx   = '0;
        if (!chValid) begin
            statusNx[ST_INVALID] = 1'b1;
        end else begin
            statusNx[ST_ACCEPTED] = (cmdReg.opcode == OP_START) && !selBusy && !selDone;
            statusNx[ST_BUSY]     = selBusy;
            statusNx[ST_DONE]     = selDone;
            statusNx[ST_PASS]     = selPass;
            statusNx[ST_TIMEOUT]  = selFlag;
            dataNx[DATA_W-1 -: 8] = selErr;
            dataNx[23:16]         = {5'd0, cmdReg.channel};
            dataNx[CNT_W-1:0]     = selCnt;
        end
    end

    sandbox_indicator uIndicator (
        .masterClock (masterClock),
        .reset       (reset),
        .slowClock   (slowClock),
        .accept      (isDecode),
        .rxIndicator (rxIndicator)
    );

endmodule

// File: tb/tb_sandbox_dispatcher.sv
// Directed bench for sandbox_dispatcher: handshake timing, start/query/abort/
// clear, watchdog boundary, invalid channel, indicator blink, mid-op reset.
module tb_sandbox_dispatcher;
    import sandbox_pkg::*;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 32;

    logic                masterClock = 1'b0;
    logic                reset, slowClock, dataReceived;
    logic [7:0]          control;
    logic [DATA_W-1:0]   inputData;
    logic                clearDR, transmitData, rxIndicator;
    logic [7:0]          status;
    logic [DATA_W-1:0]   outputData;
    logic [NUM_CH-1:0]   engRun, engBusy, engDone, engPass;
    logic [8*NUM_CH-1:0] engErrInstr;

    int tests = 0;
    int fails = 0;
    int runPulses [NUM_CH];
    logic [7:0]  rspStatus;
    logic [31:0] rspData;
    int txLat, ackLat, dropLat;
    logic txHeld;

    sandbox_dispatcher #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CNT_W(16), .TIMEOUT_CYC(8)) dut (
        .masterClock  (masterClock),
        .reset        (reset),
        .slowClock    (slowClock),
        .dataReceived (dataReceived),
        .control      (control),
        .inputData    (inputData),
        .clearDR      (clearDR),
        .transmitData (transmitData),
        .status       (status),
        .outputData   (outputData),
        .rxIndicator  (rxIndicator),
        .engRun       (engRun),
        .engBusy      (engBusy),
        .engDone      (engDone),
        .engPass      (engPass),
        .engErrInstr  (engErrInstr)
    );

    always #5 masterClock = ~masterClock;

    always @(negedge masterClock)
        for (int c = 0; c < NUM_CH; c++) if (engRun[c]) runPulses[c]++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge masterClock);
        #1;
    endtask

    function automatic int totalPulses();
        int s = 0;
        for (int c = 0; c < NUM_CH; c++) s += runPulses[c];
        return s;
    endfunction

    // Full host handshake; records latencies and the response words
    task automatic doCmd(input opcode_t op, input logic [2:0] ch, input int holdExtra);
        int n;
        control      = {3'b101, ch, op};
        dataReceived = 1'b1;
        n = 0;
        while (!transmitData && n < 20) begin step(); n++; end
        txLat     = n;
        rspStatus = status;
        rspData   = outputData;
        n = 0;
        while (!clearDR && n < 20) begin step(); n++; end
        ackLat = n;
        repeat (holdExtra) step();
        txHeld       = transmitData && clearDR;
        dataReceived = 1'b0;
        n = 0;
        while ((transmitData || clearDR) && n < 20) begin step(); n++; end
        dropLat = n;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: bench did not finish, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset        = 1'b0;
        slowClock    = 1'b0;
        dataReceived = 1'b0;
        control      = '0;
        inputData    = 32'hDEAD_BEEF;
        engBusy      = '0;
        engDone      = '0;
        engPass      = '0;
        engErrInstr  = 32'h002A_0000;
        repeat (3) step();
        chk("rst_status", status, 0);
        chk("rst_data", outputData, 0);
        chk("rst_tx", transmitData, 0);
        chk("rst_clr", clearDR, 0);
        chk("rst_run", engRun, 0);
        chk("rst_rx", rxIndicator, 0);
        reset = 1'b1;
        step();

        doCmd(OP_START, 3'd1, 0);
        chk("start1_txlat", txLat, 2);
        chk("start1_acklat", ackLat, 2);
        chk("start1_droplat", dropLat, 2);
        chk("start1_status", rspStatus, 32'h01);
        chk("start1_data", rspData, 32'h0001_0001);
        chk("start1_pulses", runPulses[1], 1);
        chk("start1_total", totalPulses(), 1);

        doCmd(OP_QUERY, 3'd1, 3);
        chk("query1_held", txHeld, 1);
        chk("query1_droplat", dropLat, 1);
        chk("query1_status", rspStatus, 32'h00);
        chk("query1_data", rspData, 32'h0001_0001);

        engBusy[1] = 1'b1;
        doCmd(OP_START, 3'd1, 0);
        engBusy[1] = 1'b0;
        chk("startbusy_status", rspStatus, 32'h02);
        chk("startbusy_data", rspData, 32'h0001_0001);
        chk("startbusy_pulses", totalPulses(), 1);

        engDone[2] = 1'b1;
        doCmd(OP_QUERY, 3'd2, 0);
        engDone[2] = 1'b0;
        chk("query2_status", rspStatus, 32'h04);
        chk("query2_data", rspData, 32'h2A02_0000);

        engDone[3] = 1'b1;
        engPass[3] = 1'b1;
        doCmd(OP_QUERY, 3'd3, 0);
        chk("query3_status", rspStatus, 32'h0C);
        chk("query3_data", rspData, 32'h0003_0000);
        doCmd(OP_START, 3'd3, 0);
        chk("startdone_status", rspStatus, 32'h0C);
        chk("startdone_pulses", totalPulses(), 1);

        engBusy[0] = 1'b1;
        repeat (7) step();
        engBusy[0] = 1'b0;
        doCmd(OP_QUERY, 3'd0, 0);
        chk("wd7_status", rspStatus, 32'h00);
        engBusy[0] = 1'b1;
        repeat (8) step();
        engBusy[0] = 1'b0;
        doCmd(OP_QUERY, 3'd0, 0);
        chk("wd8_status", rspStatus, 32'h20);
        doCmd(OP_CLEAR_STATS, 3'd0, 0);
        chk("clr0_status", rspStatus, 32'h00);
        doCmd(OP_QUERY, 3'd0, 0);
        chk("clr0_query", rspStatus, 32'h00);

        doCmd(OP_ABORT, 3'd2, 0);
        chk("abort2_status", rspStatus, 32'h20);
        chk("abort2_data", rspData, 32'h2A02_0000);
        doCmd(OP_QUERY, 3'd2, 0);
        chk("abort2_query", rspStatus, 32'h20);

        doCmd(OP_CLEAR_STATS, 3'd1, 0);
        chk("clr1_data", rspData, 32'h0001_0000);

        doCmd(OP_START, 3'd5, 0);
        chk("ch5_status", rspStatus, 32'h10);
        chk("ch5_data", rspData, 32'h0);
        chk("ch5_pulses", totalPulses(), 1);
        doCmd(OP_QUERY, 3'd4, 0);
        chk("ch4_status", rspStatus, 32'h10);

        chk("ind_wait", rxIndicator, 0);
        slowClock = 1'b1; repeat (5) step();
        slowClock = 1'b0; repeat (5) step();
        chk("ind_on", rxIndicator, 1);
        slowClock = 1'b1; repeat (5) step();
        chk("ind_still_on", rxIndicator, 1);
        slowClock = 1'b0; repeat (5) step();
        chk("ind_off", rxIndicator, 0);

        control      = {3'b000, 3'd3, OP_QUERY};
        dataReceived = 1'b1;
        repeat (3) step();
        chk("hold_tx", transmitData, 1);
        chk("hold_status", status, 32'h0C);
        reset = 1'b0;
        step();
        chk("midrst_tx", transmitData, 0);
        chk("midrst_clr", clearDR, 0);
        chk("midrst_status", status, 0);
        chk("midrst_data", outputData, 0);
        chk("midrst_run", engRun, 0);
        chk("midrst_rx", rxIndicator, 0);
        reset = 1'b1;
        doCmd(OP_QUERY, 3'd3, 0);
        chk("postrst_txlat", txLat, 2);
        chk("postrst_status", rspStatus, 32'h0C);
        chk("postrst_data", rspData, 32'h0003_0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sandbox_dispatcher.md
SANDBOX_DISPATCHER -- requirements
Module: sandbox_dispatcher

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of engine channels (1..8).
REQ-002 SHALL have parameter DATA_W, default 32, host data word width (>=32).
REQ-003 SHALL have parameter CNT_W, default 16, per-channel run-counter width (<=16).
REQ-004 SHALL have parameter TIMEOUT_CYC, default 1000000, maximum busy cycles before timeout (>=2).
REQ-005 SHALL have port masterClock  input  1  operating clock, all logic on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-007 SHALL have port slowClock  input  1  indicator timing clock, sampled in the masterClock domain.
REQ-008 SHALL have port dataReceived  input  1  host data-valid flag.
REQ-009 SHALL have port control  input  8  command byte: [1:0] opcode, [4:2] channel, [7:5] ignored.
REQ-010 SHALL have port inputData  input  DATA_W  command argument (unused by the current opcodes).
REQ-011 SHALL have port clearDR  output  1  acknowledge; releases the host flag.
REQ-012 SHALL have port transmitData  output  1  response-ready request.
REQ-013 SHALL have port status  output  8  response status byte.
REQ-014 SHALL have port outputData  output  DATA_W  response data word.
REQ-015 SHALL have port rxIndicator  output  1  one blink per accepted command.
REQ-016 SHALL have port engRun  output  NUM_CH  one-cycle start pulse per channel.
REQ-017 SHALL have port engBusy, engDone, engPass  input  NUM_CH  per-channel running/finished/passed flags.
REQ-018 SHALL have port engErrInstr  input  8*NUM_CH  packed failing-instruction index; channel c occupies bits [8c+7:8c].

Function
REQ-019 SHALL decode opcodes as 00 QUERY, 01 START, 10 ABORT and 11 CLEAR_STATS.
REQ-020 SHALL treat channel >= NUM_CH as invalid: set status[4]=1, take no action and return zero outputData.
REQ-021 SHALL implement FSM IDLE->DECODE->RESPOND->HOLD->ACK->WAIT_DROP->IDLE; IDLE leaves only on dataReceived=1, and WAIT_DROP leaves only on dataReceived=0.
REQ-022 SHALL latch control in IDLE, load status and outputData in DECODE, and assert transmitData in RESPOND, two cycles after dataReceived is sampled high.
REQ-023 SHALL assert clearDR two cycles after transmitData; both SHALL drop in the first cycle WAIT_DROP samples dataReceived=0.
REQ-024 SHALL hold status and outputData stable from DECODE until the next DECODE.
REQ-025 SHALL, for START, pulse engRun[c] for exactly one cycle (in DECODE) only if engBusy[c]=0 and engDone[c]=0, and set status[0]=1 (accepted); otherwise status[0]=0 and no pulse.
REQ-026 SHALL, for ABORT, force channel c's timeout flag to 1; engBusy is not affected.
REQ-027 SHALL, for CLEAR_STATS, zero channel c's run counter and timeout flag.
REQ-028 SHALL report status bits as: [1] engBusy[c], [2] engDone[c], [3] engPass[c], [5] timeout flag c; bits [7:6] are 0.
REQ-029 SHALL report outputData as: [DATA_W-1:DATA_W-8] engErrInstr of c, [23:16] zero-extended channel, [CNT_W-1:0] run counter c; all other bits 0.
REQ-030 SHALL increment channel c's run counter on each engRun[c] pulse, saturating at all-ones.
REQ-031 SHALL keep a watchdog per channel that counts while engBusy[c]=1 and clears when engBusy[c]=0; on reaching TIMEOUT_CYC it SHALL set the sticky timeout flag.
REQ-032 SHALL let CLEAR_STATS win over a same-cycle watchdog expiry.
REQ-033 SHALL run the indicator FSM as: on an accept, wait for slowClock high, then low, then set rxIndicator=1; then wait for high, then low, then clear it; accepts during a blink are coalesced.

Reset
REQ-034 SHALL, with reset=0 at a clock edge, force FSM to IDLE and set clearDR, transmitData, engRun, rxIndicator, status, outputData, counters, watchdogs and flags to 0.
REQ-035 SHALL abandon any in-flight transaction on mid-operation reset; after reset release the block SHALL wait for a fresh dataReceived=1 sampled in IDLE.

Structure
REQ-036 SHALL put opcode constants, status bit positions and FSM state encodings in shared package sandbox_pkg.
REQ-037 SHALL implement the blink FSM as sub-module sandbox_indicator.

Verification
REQ-038 SHALL cover: START ch1 while idle -> engRun[1] single pulse; status=8'h01; run count 1; transmitData 2 cycles after dataReceived.
REQ-039 SHALL cover: START ch1 with engBusy[1]=1 -> no pulse; status[0]=0 and status[1]=1.
REQ-040 SHALL cover: QUERY ch2 with done=1, pass=0, errInstr=8'h2A -> status=8'h04; outputData=32'h2A02_0000 | count.
REQ-041 SHALL cover: with TIMEOUT_CYC=8, engBusy[0] held for 8 cycles -> QUERY ch0 gives status[5]=1; CLEAR_STATS ch0 -> 0.
REQ-042 SHALL cover: channel 5 with NUM_CH=4 -> status=8'h10; outputData=0; no engRun.
REQ-043 SHALL cover: reset=0 asserted in HOLD -> all outputs 0 next cycle; with dataReceived still high after release, a new transaction starts.
